// File: rtl/legal_move_arbiter.sv
// ---------------------------------------------------------------------------
// legal_move_arbiter
//
// Time-shares the single legal-move lookup (8x8 maze, 4 legal bits per cell)
// between Pac-Man (requester 0) and the four ghosts (requesters 1..4).
// Requests are picked round-robin in IDLE. The winner's pixel position is
// latched. In-grid positions go through the lookup, which has a fixed
// latency. Off-grid positions are answered at once with "no legal moves".
// The 4-bit result goes back to the winner with a one-cycle valid pulse.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   req           per-requester request level
//   req_xpos      packed x positions, requester i at [10i+9:10i]
//   req_ypos      packed y positions, same packing
//   grant         one-hot, requester currently being served
//   rsp_valid     one-cycle pulse to the served requester
//   rsp_legal     {left,right,up,down}, valid while rsp_valid is non-zero
//   lookup_valid  high while a lookup is in flight
//   lookup_xpos   latched x of the winner
//   lookup_ypos   latched y of the winner
//   lookup_legal  lookup result, same bit order as rsp_legal
//   busy          high whenever the FSM is not in IDLE
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting; samples req and picks a winner round-robin from rr_ptr
// LOOK  | lookup in flight; lat_cnt counts down the lookup latency
// RESP  | rsp_valid pulse to the winner; rr_ptr advances past the winner
// ---------------------------------------------------------------------------
module legal_move_arbiter #(
   parameter int N_REQ      = 5,
   parameter int LOOKUP_LAT = 1,
   parameter int SF         = 60,
   parameter int S_X        = 150,
   parameter int S_Y        = 34,
   parameter int GRID_N     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [10*N_REQ-1:0]  req_xpos,
   input  logic [10*N_REQ-1:0]  req_ypos,
   output logic [N_REQ-1:0]     grant,
   output logic [N_REQ-1:0]     rsp_valid,
   output logic [3:0]           rsp_legal,
   output logic                 lookup_valid,
   output logic [9:0]           lookup_xpos,
   output logic [9:0]           lookup_ypos,
   input  logic [3:0]           lookup_legal,
   output logic                 busy
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int X_LO  = S_X;
   localparam int X_HI  = S_X + GRID_N * SF;
   localparam int Y_LO  = S_Y;
   localparam int Y_HI  = S_Y + GRID_N * SF;

   localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOOK = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] win;
   logic [2:0]       lat_cnt;

   logic             sel_found;
   logic [IDX_W-1:0] sel_idx;
   logic [9:0]       sel_x;
   logic [9:0]       sel_y;
   logic             sel_in_grid;

   // Round-robin search: first set req bit at or after rr_ptr, wrapping.
   always_comb begin
      int idx;
      sel_found = 1'b0;
      sel_idx   = '0;
      idx       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!sel_found && req[IDX_W'(idx)]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(idx);
         end
      end
   end

   // Position mux for the selected requester; constant slices only.
   always_comb begin
      sel_x = '0;
      sel_y = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel_idx == IDX_W'(i)) begin
            sel_x = req_xpos[10*i +: 10];
            sel_y = req_ypos[10*i +: 10];
         end
      end
   end

   // The compare runs on the value being latched this edge, so the
   // IDLE decision and the latched copy always agree.
   always_comb begin
      sel_in_grid = (32'(sel_x) >= 32'(X_LO)) && (32'(sel_x) < 32'(X_HI)) &&
                    (32'(sel_y) >= 32'(Y_LO)) && (32'(sel_y) < 32'(Y_HI));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         win          <= '0;
         lat_cnt      <= '0;
         grant        <= '0;
         rsp_valid    <= '0;
         rsp_legal    <= '0;
         lookup_valid <= 1'b0;
         lookup_xpos  <= '0;
         lookup_ypos  <= '0;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_found) begin
                  win         <= sel_idx;
                  grant       <= ONE_HOT0 << sel_idx;
                  lookup_xpos <= sel_x;
                  lookup_ypos <= sel_y;
                  busy        <= 1'b1;
                  if (sel_in_grid) begin
                     lookup_valid <= 1'b1;
                     lat_cnt      <= 3'(LOOKUP_LAT);
                     state        <= LOOK;
                  end else begin
                     rsp_legal <= 4'b0000;
                     rsp_valid <= ONE_HOT0 << sel_idx;
                     state     <= RESP;
                  end
               end
            end

            LOOK: begin
               lat_cnt <= lat_cnt - 3'd1;
               if (lat_cnt == 3'd1) begin
                  rsp_legal    <= lookup_legal;
                  rsp_valid    <= grant;
                  lookup_valid <= 1'b0;
                  state        <= RESP;
               end
            end

            RESP: begin
               rsp_valid <= '0;
               grant     <= '0;
               busy      <= 1'b0;
               if (win == IDX_W'(N_REQ - 1))
                  rr_ptr <= '0;
               else
                  rr_ptr <= win + 1'b1;
               state <= IDLE;
            end

            default: begin
               rsp_valid    <= '0;
               grant        <= '0;
               lookup_valid <= 1'b0;
               busy         <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_legal_move_arbiter.sv
// ---------------------------------------------------------------------------
// tb_legal_move_arbiter
//
// Directed bench for legal_move_arbiter. Two instances share one clock:
// dut_a with a lookup latency of 1 and dut_b with a latency of 3. Inputs are
// driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_legal_move_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b;
   logic [4:0]  req_a, req_b;
   logic [49:0] x_a, y_a, x_b, y_b;
   logic [3:0]  ll_a, ll_b;

   logic [4:0]  grant_a, rv_a, grant_b, rv_b;
   logic [3:0]  rl_a, rl_b;
   logic        lv_a, lv_b, busy_a, busy_b;
   logic [9:0]  lx_a, ly_a, lx_b, ly_b;

   int n_chk  = 0;
   int n_fail = 0;

   legal_move_arbiter #(.N_REQ(5), .LOOKUP_LAT(1)) dut_a (
      .clk(clk), .rst_n(rst_a), .req(req_a), .req_xpos(x_a), .req_ypos(y_a),
      .grant(grant_a), .rsp_valid(rv_a), .rsp_legal(rl_a),
      .lookup_valid(lv_a), .lookup_xpos(lx_a), .lookup_ypos(ly_a),
      .lookup_legal(ll_a), .busy(busy_a)
   );

   legal_move_arbiter #(.N_REQ(5), .LOOKUP_LAT(3)) dut_b (
      .clk(clk), .rst_n(rst_b), .req(req_b), .req_xpos(x_b), .req_ypos(y_b),
      .grant(grant_b), .rsp_valid(rv_b), .rsp_legal(rl_b),
      .lookup_valid(lv_b), .lookup_xpos(lx_b), .lookup_ypos(ly_b),
      .lookup_legal(ll_b), .busy(busy_b)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pos_a(input int i, input int x, input int y);
      x_a[10*i +: 10] = 10'(x);
      y_a[10*i +: 10] = 10'(y);
   endtask

   task automatic pos_b(input int i, input int x, input int y);
      x_b[10*i +: 10] = 10'(y == 0 ? x : x);
      y_b[10*i +: 10] = 10'(y);
   endtask

   // Single-requester transaction on dut_a (latency 1); ll_a = 4'b1111.
   task automatic one_a(input int i, input int x, input int y,
                        input bit in_grid, input string tag);
      req_a = 5'(1 << i);
      pos_a(i, x, y);
      cyc(1);
      if (in_grid) begin
         check({tag, "_lv"}, 32'(lv_a), 32'd1);
         check({tag, "_rv0"}, 32'(rv_a), 32'd0);
         req_a = '0;
         cyc(1);
      end else begin
         req_a = '0;
      end
      check({tag, "_rv"}, 32'(rv_a), 32'(1 << i));
      check({tag, "_rl"}, 32'(rl_a), in_grid ? 32'hf : 32'h0);
      check({tag, "_lv_off"}, 32'(lv_a), 32'd0);
      cyc(1);
      check({tag, "_idle"}, 32'({busy_a, rv_a}), 32'd0);
   endtask

   initial begin
      int np, last;
      rst_a = 1'b0; rst_b = 1'b0;
      req_a = '0;   req_b = '0;
      x_a = '0; y_a = '0; x_b = '0; y_b = '0;
      ll_a = '0; ll_b = '0;
      cyc(2);

      // Reset state
      check("rst_grant",  32'(grant_a), 32'd0);
      check("rst_rv",     32'(rv_a),    32'd0);
      check("rst_rl",     32'(rl_a),    32'd0);
      check("rst_lv",     32'(lv_a),    32'd0);
      check("rst_pos",    32'({lx_a, ly_a}), 32'd0);
      check("rst_busy",   32'(busy_a),  32'd0);
      check("rst_b",      32'({grant_b, rv_b, lv_b, busy_b}), 32'd0);
      rst_a = 1'b1; rst_b = 1'b1;

      // Pac-Man at the top-left corner cell, latency 1
      req_a = 5'b00001; pos_a(0, 150, 34); ll_a = 4'b0001;
      cyc(1);
      check("t1_lv",    32'(lv_a),    32'd1);
      check("t1_x",     32'(lx_a),    32'd150);
      check("t1_y",     32'(ly_a),    32'd34);
      check("t1_grant", 32'(grant_a), 32'h01);
      check("t1_busy",  32'(busy_a),  32'd1);
      check("t1_rv0",   32'(rv_a),    32'd0);
      req_a = '0;
      cyc(1);
      check("t1_rv",    32'(rv_a),    32'h01);
      check("t1_rl",    32'(rl_a),    32'h1);
      check("t1_lv0",   32'(lv_a),    32'd0);
      cyc(1);
      check("t1_idle",  32'({grant_a, rv_a, busy_a}), 32'd0);

      // All five requesting continuously; rr_ptr cleared by reset first
      rst_a = 1'b0;
      cyc(1);
      rst_a = 1'b1;
      for (int i = 0; i < 5; i++) pos_a(i, 200 + 40 * i, 100 + 50 * i);
      ll_a  = 4'b1010;
      req_a = 5'b11111;
      np = 0; last = 0;
      for (int c = 1; c <= 22; c++) begin
         cyc(1);
         check("rr_onehot", 32'($onehot0(rv_a)), 32'd1);
         if (rv_a != '0) begin
            if (np < 7) check("rr_order", 32'(rv_a), 32'(1 << (np % 5)));
            if (np > 0) check("rr_spacing", 32'(c - last), 32'd3);
            check("rr_rl", 32'(rl_a), 32'ha);
            last = c;
            np++;
         end
      end
      check("rr_count", 32'(np), 32'd7);
      req_a = '0;
      cyc(3);

      // Off-grid and boundary positions
      ll_a = 4'b1111;
      one_a(0, 149, 100, 1'b0, "offx_lo");
      one_a(2, 630, 100, 1'b0, "offx_hi");
      one_a(3, 300, 33,  1'b0, "offy_lo");
      one_a(1, 300, 514, 1'b0, "offy_hi");
      one_a(4, 629, 513, 1'b1, "edge_in");

      // Latency 3: ghost 2 drops req one cycle after sampling
      ll_b = 4'b1100; req_b = 5'b00100; pos_b(2, 300, 300);
      cyc(1);
      check("l3_lv1",    32'(lv_b),    32'd1);
      check("l3_grant",  32'(grant_b), 32'h04);
      req_b = '0;
      cyc(1);
      check("l3_lv2",    32'({lv_b, rv_b}), 32'h20);
      cyc(1);
      check("l3_lv3",    32'({lv_b, rv_b}), 32'h20);
      cyc(1);
      check("l3_rv",     32'(rv_b),    32'h04);
      check("l3_rl",     32'(rl_b),    32'hc);
      check("l3_lv_off", 32'(lv_b),    32'd0);
      cyc(1);
      check("l3_idle",   32'({busy_b, rv_b}), 32'd0);

      // Requester 3 served, then 0 and 3 together: search wraps 4 -> 0
      req_b = 5'b01000; pos_b(3, 400, 400); pos_b(0, 160, 40);
      cyc(1);
      check("wr_g3",   32'(grant_b), 32'h08);
      req_b = '0;
      cyc(3);
      check("wr_rv3",  32'(rv_b),    32'h08);
      cyc(1);
      req_b = 5'b01001;
      cyc(1);
      check("wr_g0",   32'(grant_b), 32'h01);
      cyc(3);
      check("wr_rv0",  32'(rv_b),    32'h01);
      cyc(2);
      check("wr_g3b",  32'(grant_b), 32'h08);
      req_b = '0;
      cyc(3);
      check("wr_rv3b", 32'(rv_b),    32'h08);
      cyc(1);

      // Reset in the middle of a lookup
      req_b = 5'b00110; pos_b(1, 250, 250); pos_b(2, 350, 350);
      cyc(1);
      check("rl_lv",    32'(lv_b), 32'd1);
      rst_b = 1'b0;
      cyc(1);
      check("rl_clear", 32'({grant_b, rv_b, lv_b, busy_b}), 32'd0);
      check("rl_pos",   32'({lx_b, ly_b}), 32'd0);
      rst_b = 1'b1;
      cyc(1);
      check("rl_g1",    32'(grant_b), 32'h02);
      check("rl_x1",    32'(lx_b),    32'd250);
      cyc(3);
      check("rl_rv1",   32'(rv_b),    32'h02);
      cyc(2);
      check("rl_g2",    32'(grant_b), 32'h04);
      req_b = '0;
      cyc(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/legal_move_arbiter.md
# legal_move_arbiter

Round-robin arbiter that time-shares the single legal-move lookup (8x8 maze grid, 4 legal bits per cell) between Pac-Man and the four ghosts. Each mover raises a request with its pixel position. The arbiter serialises the requests onto the lookup port, waits the lookup's fixed latency, and returns the 4-bit legal-move word to the winner with a one-cycle valid pulse. Positions outside the maze are answered directly with no legal moves and never reach the lookup.

## Interface
- N_REQ, 5, number of requesters; index 0 = Pac-Man, 1..4 = ghosts
- LOOKUP_LAT, 1, cycles from lookup_valid rising to lookup_legal being valid; range 1..7
- SF, 60, cell size in pixels
- S_X, 150, maze left edge in pixels
- S_Y, 34, maze top edge in pixels
- GRID_N, 8, cells per row/column
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req  in  N_REQ  per-requester request level
- req_xpos  in  10*N_REQ  packed x positions; requester i at [10i+9:10i]
- req_ypos  in  10*N_REQ  packed y positions, same packing
- grant  out  N_REQ  one-hot, marks the requester currently being served
- rsp_valid  out  N_REQ  one-cycle pulse to the served requester
- rsp_legal  out  4  {left,right,up,down}; valid while any rsp_valid bit is high
- lookup_valid  out  1  high while a lookup is in flight
- lookup_xpos  out  10  latched x of the winner
- lookup_ypos  out  10  latched y of the winner
- lookup_legal  in  4  lookup result, same bit order as rsp_legal
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOOK, RESP. Reset value of the state is IDLE.
- Reset values: rr_ptr=0, lat_cnt=0, grant=0, rsp_valid=0, rsp_legal=0, lookup_valid=0, lookup_xpos=0, lookup_ypos=0, busy=0.
- Round-robin selection in IDLE:
  - Search req starting at index rr_ptr, ascending, wrapping at N_REQ-1 to 0.
  - The first set bit wins; latch its index, x and y.
- In-grid test uses the latched x/y, unsigned 10-bit compares:
  - S_X <= x < S_X+GRID_N*SF (150..629).
  - S_Y <= y < S_Y+GRID_N*SF (34..513).
- IDLE with any req set:
  - In grid: go to LOOK, lat_cnt=LOOKUP_LAT.
  - Out of grid: go to RESP, rsp_legal=4'b0000.
- LOOK:
  - lookup_valid=1; lookup_xpos and lookup_ypos hold the latched x/y.
  - lat_cnt decrements each cycle.
  - On the edge where lat_cnt==1: capture lookup_legal into rsp_legal, go to RESP.
- RESP:
  - rsp_valid[win]=1 for exactly one cycle.
  - rr_ptr = (win+1) mod N_REQ.
  - Go to IDLE.
- grant[win] is high in LOOK and RESP and zero in IDLE.
- Requests are sampled only in IDLE. A req that drops during LOOK or RESP does not abort the transaction; the rsp_valid pulse is still issued.
- A requester whose req is still high in the IDLE cycle after its rsp_valid is treated as a new request and competes under round robin.
- Requesters must hold x/y stable only until the IDLE sampling edge; the arbiter works from latched copies.
- Simultaneous requests: at most one winner per transaction. rsp_valid is never multi-hot.
- rst_n low in any state: next cycle is IDLE with all reset values. A pending rsp_valid is dropped and rr_ptr returns to 0.

## Timing
- In-grid request, req high at IDLE edge E0:
  - lookup_valid high for cycles E0+1 .. E0+LOOKUP_LAT.
  - rsp_valid high in cycle E0+LOOKUP_LAT+1.
  - Back in IDLE at E0+LOOKUP_LAT+2.
  - Throughput: one lookup per LOOKUP_LAT+2 cycles.
- Off-grid request: rsp_valid in cycle E0+1, IDLE at E0+2, lookup_valid never asserted.
- All outputs are registered; no combinational path from req or lookup_legal to any output.

## Test plan
- Reset, then req=5'b00001 at (150,34), lookup returns 4'b0001, LOOKUP_LAT=1 -> lookup_valid for 1 cycle with lookup_xpos=150 and lookup_ypos=34; rsp_valid=5'b00001 with rsp_legal=4'b0001 on cycle 2 after sampling.
- req=5'b11111 held continuously -> grant order 0,1,2,3,4,0,1; rsp_valid pulses spaced 3 cycles apart (LOOKUP_LAT=1); never multi-hot.
- Off-grid: x=149, y=100, and separately x=630 -> rsp_legal=4'b0000 on cycle 1 after sampling, lookup_valid stays 0. Boundary: x=629, y=513 -> goes through LOOK.
- LOOKUP_LAT=3; ghost 2 req drops one cycle after sampling, lookup_legal=4'b1100 -> lookup_valid for 3 cycles; rsp_valid[2] still pulses with rsp_legal=4'b1100.
- rst_n low during LOOK with req=5'b00110 -> next cycle IDLE, all outputs 0, no rsp_valid. After release, requester 1 is served first (rr_ptr=0).
- Requester 3 served, then req=5'b01001 -> requester 0 wins next (rr_ptr=4 search wraps 4 -> 0), then requester 3.
